// File: rtl/rsa_modexp_seq_if.sv
// ----------------------------------------------------------------------------
// rsa_modexp_seq_if
// Request/response bus between the modular exponentiator (master) and the
// 2*OP_W-bit non-restoring divider (slave) that performs every reduction.
//
// Signals
//   div_start     master->slave  1-cycle request pulse
//   div_dividend  master->slave  value to reduce, held until div_done
//   div_divisor   master->slave  {zeros, modulus}, held until div_done
//   div_done      slave->master  completion strobe
//   div_rem       slave->master  remainder, valid with div_done
// ----------------------------------------------------------------------------
interface rsa_modexp_seq_if #(
    parameter int DW = 32
);
    logic          div_start;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic          div_done;
    logic [DW-1:0] div_rem;

    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        input  div_done,
        input  div_rem
    );

    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        output div_done,
        output div_rem
    );
endinterface

// File: rtl/rsa_modexp_seq.sv
// ----------------------------------------------------------------------------
// rsa_modexp_seq
// Sequential modular exponentiator: result = base^exp mod modulus, computed
// left-to-right by square-and-multiply. Every full-width product is reduced
// by an external divider reached through div_if; the remainder becomes the
// new running value. One exponentiation in flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   start_i      request; accepted only while ready_o=1, latches operands
//   base_i       message / ciphertext (OP_W)
//   exp_i        exponent (EXP_W)
//   modulus_i    modulus n (OP_W)
//   ready_o      high in IDLE
//   busy_o       high from the cycle after an accepted start through done
//   done_o       1-cycle completion pulse; result_o/err_o valid from here
//   err_o        raised with done_o when modulus was 0, cleared on next start
//   result_o     last result, held until overwritten by the next done
//   div_if       master side of the divider bus
//
// Build option
//   SKIP_LZ_EN   when defined, leading zero exponent bits are skipped (r is
//                still 1 there, so squaring them is wasted time). Result is
//                identical in both builds; only latency changes.
// ----------------------------------------------------------------------------
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | waiting for start; operands latched on acceptance
//  S_CHK    | trap modulus==0 and exp==0, else issue base reduction
//  S_BRED   | waiting for base mod n, stored as b
//  S_SQ     | register r*r and request its reduction
//  S_SQRED  | waiting for r*r mod n
//  S_MUL    | register r*b and request its reduction (exp bit set)
//  S_MULRED | waiting for r*b mod n
//  S_NEXT   | move to next lower exponent bit or finish
//  S_FIN    | done pulse cycle, then back to IDLE
// ----------------------------------------------------------------------------
module rsa_modexp_seq #(
    parameter int OP_W  = 16,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [OP_W-1:0]  base_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [OP_W-1:0]  modulus_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [OP_W-1:0]  result_o,
    rsa_modexp_seq_if.master div_if
);

    localparam int DW = 2 * OP_W;
    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_BRED,
        S_SQ,
        S_SQRED,
        S_MUL,
        S_MULRED,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [OP_W-1:0]  base_q;
    logic [EXP_W-1:0] exp_q;
    logic [OP_W-1:0]  mod_q;
    logic [OP_W-1:0]  r_q;
    logic [OP_W-1:0]  b_q;
    logic [IW-1:0]    i_q;
    logic [OP_W-1:0]  result_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             div_start_q;
    logic [DW-1:0]    div_dividend_q;
    logic [DW-1:0]    div_divisor_q;

    logic [OP_W-1:0]  rem_d;
    logic [DW-1:0]    sq_d;
    logic [DW-1:0]    mul_d;
    logic [IW-1:0]    msb_d;

    // Remainder is always < modulus, so the upper half carries no information.
    assign rem_d = OP_W'(div_if.div_rem);

    // Full-width products; both operands are < modulus so nothing overflows.
    assign sq_d  = DW'(r_q) * DW'(r_q);
    assign mul_d = DW'(r_q) * DW'(b_q);

`ifdef SKIP_LZ_EN
    // Index of the highest set exponent bit; only consulted when exp != 0.
    always_comb begin
        msb_d = '0;
        for (int k = 0; k < EXP_W; k++) begin
            if (exp_q[k]) begin
                msb_d = IW'(k);
            end
        end
    end
`else
    assign msb_d = IW'(EXP_W - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            exp_q          <= '0;
            mod_q          <= '0;
            r_q            <= '0;
            b_q            <= '0;
            i_q            <= '0;
            result_q       <= '0;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            div_start_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            div_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_q  <= base_i;
                        exp_q   <= exp_i;
                        mod_q   <= modulus_i;
                        r_q     <= OP_W'(1);
                        i_q     <= IW'(EXP_W - 1);
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHK;
                    end
                end

                S_CHK: begin
                    if (mod_q == '0) begin
                        // Division by zero is never requested.
                        err_q    <= 1'b1;
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else if (exp_q == '0) begin
                        // x^0 = 1, which reduces to 0 only for modulus 1.
                        result_q <= (mod_q == OP_W'(1)) ? '0 : OP_W'(1);
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else begin
                        i_q            <= msb_d;
                        div_dividend_q <= {{OP_W{1'b0}}, base_q};
                        div_divisor_q  <= {{OP_W{1'b0}}, mod_q};
                        div_start_q    <= 1'b1;
                        state_q        <= S_BRED;
                    end
                end

                S_BRED: begin
                    // Reducing the base first keeps b < modulus even when
                    // base >= modulus, so r*b always fits in DW bits.
                    if (div_if.div_done) begin
                        b_q     <= rem_d;
                        state_q <= S_SQ;
                    end
                end

                S_SQ: begin
                    div_dividend_q <= sq_d;
                    div_start_q    <= 1'b1;
                    state_q        <= S_SQRED;
                end

                S_SQRED: begin
                    if (div_if.div_done) begin
                        r_q     <= rem_d;
                        state_q <= exp_q[i_q] ? S_MUL : S_NEXT;
                    end
                end

                S_MUL: begin
                    div_dividend_q <= mul_d;
                    div_start_q    <= 1'b1;
                    state_q        <= S_MULRED;
                end

                S_MULRED: begin
                    if (div_if.div_done) begin
                        r_q     <= rem_d;
                        state_q <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (i_q == '0) begin
                        result_q <= r_q;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else begin
                        i_q     <= i_q - IW'(1);
                        state_q <= S_SQ;
                    end
                end

                S_FIN: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;

    assign div_if.div_start    = div_start_q;
    assign div_if.div_dividend = div_dividend_q;
    assign div_if.div_divisor  = div_divisor_q;

endmodule
